// File: rtl/s208_z_window_monitor_if.sv
// ---------------------------------------------------------------------------
// s208_z_window_monitor_if
//   Record-drain handshake between the window monitor and the reliability-test
//   harness. The monitor is the master: it presents the FIFO head record and
//   the harness accepts it with Out_Ready.
//
//   Signals
//     Out_Valid   head record available
//     Out_Ready   consumer accepts head record
//     Out_ZCount  head record: Z pulses in window      (CNT_W bits)
//     Out_Len     head record: X-active cycles          (LEN_W bits)
//     Out_Parity  even parity over {ZCount,Len}; present only when
//                 S208_MON_PARITY_EN is defined
// ---------------------------------------------------------------------------
interface s208_z_window_monitor_if #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 10
);
  logic             Out_Valid;
  logic             Out_Ready;
  logic [CNT_W-1:0] Out_ZCount;
  logic [LEN_W-1:0] Out_Len;
`ifdef S208_MON_PARITY_EN
  logic             Out_Parity;
`endif

  modport master (
    input  Out_Ready,
    output Out_Valid,
    output Out_ZCount,
    output Out_Len
`ifdef S208_MON_PARITY_EN
    ,
    output Out_Parity
`endif
  );

  modport slave (
    output Out_Ready,
    input  Out_Valid,
    input  Out_ZCount,
    input  Out_Len
`ifdef S208_MON_PARITY_EN
    ,
    input  Out_Parity
`endif
  );
endinterface

// File: rtl/s208_z_window_monitor.sv
// ---------------------------------------------------------------------------
// s208_z_window_monitor
//   Sequential stage behind the s208 combinational core. Per window it counts
//   X-qualified cycles (Len) and Z pulses (ZCount), both saturating. A window
//   closes on a rising W during an active cycle (record includes that cycle)
//   or on Clear with a non-empty window (record excludes the Clear cycle).
//   Closed records pass through one register stage and are then pushed into
//   a DEPTH-entry FIFO drained over a valid/ready handshake. A record that
//   finds the FIFO full (with no pop in the same cycle) is dropped and the
//   sticky Overflow flag is raised.
//
//   Ports
//     CK        clock, rising edge
//     Reset_N   synchronous reset, active low
//     X         core count-enable
//     Clear     core clear
//     Z         s208 Z output
//     W         s208 W output (window close strobe)
//     bus       record drain interface (master modport)
//     Overflow  sticky record-dropped flag
//
//   Optional feature macro: S208_MON_PARITY_EN
//     Adds Out_Parity on the interface, computed at push and stored per entry.
// ---------------------------------------------------------------------------
module s208_z_window_monitor #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 10,
  parameter int DEPTH = 4
) (
  input  logic                            CK,
  input  logic                            Reset_N,
  input  logic                            X,
  input  logic                            Clear,
  input  logic                            Z,
  input  logic                            W,
  s208_z_window_monitor_if.master         bus,
  output logic                            Overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] ZMAX = '1;
  localparam logic [LEN_W-1:0] LMAX = '1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc_z(input logic [CNT_W-1:0] v);
    return (v == ZMAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (v == LMAX) ? v : v + LEN_W'(1);
  endfunction

  // Window counters and W history
  logic [CNT_W-1:0] r_zcnt;
  logic [LEN_W-1:0] r_len;
  logic             r_wq;

  logic             w_active;
  logic             w_wrise;
  logic             w_clr_close;
  logic             w_close;
  logic [CNT_W-1:0] w_zcnt_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [CNT_W-1:0] w_rec_z;
  logic [LEN_W-1:0] w_rec_l;

  always_comb begin
    w_active    = X & ~Clear;
    w_wrise     = w_active & W & ~r_wq;
    w_clr_close = Clear & (r_len != '0);
    w_close     = w_wrise | w_clr_close;
    w_len_nxt   = sat_inc_len(r_len);
    w_zcnt_nxt  = Z ? sat_inc_z(r_zcnt) : r_zcnt;
    // W close records this cycle's increments; Clear close records prior counts.
    w_rec_z     = w_wrise ? w_zcnt_nxt : r_zcnt;
    w_rec_l     = w_wrise ? w_len_nxt  : r_len;
  end

  always_ff @(posedge CK) begin
    if (!Reset_N) begin
      r_zcnt <= '0;
      r_len  <= '0;
      r_wq   <= 1'b0;
    end else begin
      r_wq <= W;
      if (Clear || w_wrise) begin
        r_zcnt <= '0;
        r_len  <= '0;
      end else if (w_active) begin
        r_zcnt <= w_zcnt_nxt;
        r_len  <= w_len_nxt;
      end
    end
  end

  // ---- stage p0: closed record register ----
  logic             r_rec_vld_p0;
  logic [CNT_W-1:0] r_rec_z_p0;
  logic [LEN_W-1:0] r_rec_l_p0;

  always_ff @(posedge CK) begin
    if (!Reset_N) r_rec_vld_p0 <= 1'b0;
    else          r_rec_vld_p0 <= w_close;
  end

  always_ff @(posedge CK) begin
    if (w_close) begin
      r_rec_z_p0 <= w_rec_z;
      r_rec_l_p0 <= w_rec_l;
    end
  end

  // ---- stage p1: record FIFO ----
  logic [CNT_W-1:0] r_mem_z [DEPTH];
  logic [LEN_W-1:0] r_mem_l [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  always_comb begin
    w_valid = (r_count != '0);
    w_full  = (r_count == FULL_CNT);
    w_pop   = w_valid & bus.Out_Ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    w_push  = r_rec_vld_p0 & (~w_full | w_pop);
  end

  always_ff @(posedge CK) begin
    if (!Reset_N) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      Overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (r_rec_vld_p0 && !w_push) Overflow <= 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (w_push) begin
      r_mem_z[r_wptr] <= r_rec_z_p0;
      r_mem_l[r_wptr] <= r_rec_l_p0;
    end
  end

  assign bus.Out_Valid  = w_valid;
  assign bus.Out_ZCount = w_valid ? r_mem_z[r_rptr] : '0;
  assign bus.Out_Len    = w_valid ? r_mem_l[r_rptr] : '0;

`ifdef S208_MON_PARITY_EN
  logic r_mem_p [DEPTH];
  logic w_rec_par;

  assign w_rec_par = ^{r_rec_z_p0, r_rec_l_p0};

  always_ff @(posedge CK) begin
    if (w_push) r_mem_p[r_wptr] <= w_rec_par;
  end

  assign bus.Out_Parity = w_valid ? r_mem_p[r_rptr] : 1'b0;
`endif

endmodule
